// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side byte streams of the UART TX arbiter.
//   req_*    : NUM_REQ packed AXI-Stream requesters; lane i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
//   m_axis_* : single merged stream towards the uart core's s_axis_* input
// modport master : the arbiter (it masters m_axis and issues req_tready)
// modport slave  : the environment (requesters plus the UART TX sink)
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ*DATA_WIDTH-1:0] req_tdata;
  logic [NUM_REQ-1:0]            req_tvalid;
  logic [NUM_REQ-1:0]            req_tlast;
  logic [NUM_REQ-1:0]            req_tready;
  logic [DATA_WIDTH-1:0]         m_axis_tdata;
  logic                          m_axis_tvalid;
  logic                          m_axis_tlast;
  logic                          m_axis_tready;

  modport master (
    input  req_tdata, req_tvalid, req_tlast, m_axis_tready,
    output req_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    output req_tdata, req_tvalid, req_tlast, m_axis_tready,
    input  req_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter in front of the UART TX byte stream.
// A grant is held from the first beat until tlast (or until MAX_BURST beats),
// so packets from different requesters never interleave.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : gate for issuing new grants (a running grant always completes)
//   bus         : uart_tx_arbiter_if.master (requester streams in, merged stream out)
//   grant_valid : a requester currently holds the grant
//   grant_id    : current or most recent grantee
//   burst_cut   : one-cycle pulse after a grant is released by the beat limit

// Per-requester ready: only the grantee sees ready, and only when the
// single-entry output register can take a beat this cycle.
module uart_tx_arbiter_lane #(
  parameter int IDW  = 2,
  parameter int LANE = 0
) (
  input  logic           granted,
  input  logic [IDW-1:0] grant_id,
  input  logic           slot_free,
  output logic           ready
);
  assign ready = granted && (grant_id == IDW'(LANE)) && slot_free;
endmodule

module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  uart_tx_arbiter_if.master          bus,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       burst_cut
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                state;
  logic [IDW-1:0]        last;
  logic [IDW-1:0]        next_id;
  logic                  next_found;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_last;
  logic [NUM_REQ-1:0]    ready;
  logic                  slot_free;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  accept;
  logic                  at_limit;
  logic                  release_g;

  assign grant_valid = (state == GRANT);

  // Output register can take a beat when empty or draining this cycle.
  assign slot_free = !out_valid || bus.m_axis_tready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      uart_tx_arbiter_lane #(.IDW(IDW), .LANE(gi)) u_lane (
        .granted   (grant_valid),
        .grant_id  (grant_id),
        .slot_free (slot_free),
        .ready     (ready[gi])
      );
    end
  endgenerate

  assign bus.req_tready = ready;

  assign sel_valid = bus.req_tvalid[grant_id];
  assign sel_last  = bus.req_tlast[grant_id];
  assign sel_data  = bus.req_tdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign accept    = grant_valid && sel_valid && slot_free;
  assign at_limit  = (cnt == CW'(MAX_BURST - 1));
  assign release_g = accept && (sel_last || at_limit);

  // Round-robin pick: scan from last+NUM_REQ down to last+1 so that the
  // nearest requester after the previous grantee is written last and wins.
  always_comb begin
    next_id    = '0;
    next_found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req_tvalid[IDW'((int'(last) + k) % NUM_REQ)]) begin
        next_id    = IDW'((int'(last) + k) % NUM_REQ);
        next_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= IDW'(NUM_REQ - 1);
      grant_id  <= '0;
      cnt       <= '0;
      burst_cut <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      burst_cut <= release_g && !sel_last;

      unique case (state)
        IDLE: begin
          if (enable && next_found) begin
            state    <= GRANT;
            grant_id <= next_id;
            cnt      <= '0;
          end
        end
        GRANT: begin
          if (accept) cnt <= cnt + CW'(1);
          if (release_g) begin
            state <= IDLE;
            last  <= grant_id;
          end
        end
      endcase

      // The output register drains independently of the grant state.
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_last  <= sel_last || at_limit;
      end else if (bus.m_axis_tready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.m_axis_tdata  = out_data;
  assign bus.m_axis_tvalid = out_valid;
  assign bus.m_axis_tlast  = out_last;
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmit byte stream among NUM_REQ requesters, e.g. the CPU register path, a debug/trace source and a DSI status reporter. It sits between the requesters and the `uart` core's `s_axis_*` input. Grant is held for a whole packet, delimited by `tlast`, so bytes from different sources never interleave. A per-grant beat limit stops any single requester from starving the others.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_WIDTH, 8: byte width; must match the `uart` DATA_WIDTH.
- MAX_BURST, 64: maximum number of beats per grant, ≥1.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- enable  in  1  when low, no new grant is issued; a grant already in progress finishes normally.
- req_tdata  in  NUM_REQ*DATA_WIDTH  requester data; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_tvalid  in  NUM_REQ  per-requester valid.
- req_tlast  in  NUM_REQ  per-requester end of packet.
- req_tready  out  NUM_REQ  per-requester ready; at most one bit is high at any time.
- m_axis_tdata  out  DATA_WIDTH  data to the UART TX.
- m_axis_tvalid  out  1  valid to the UART TX.
- m_axis_tlast  out  1  forwarded `tlast`; also high on a burst-cut beat.
- m_axis_tready  in  1  ready from the UART TX (`s_axis_tready`).
- grant_valid  out  1  a requester currently holds the grant.
- grant_id  out  $clog2(NUM_REQ)  index of the current or most recent grantee.
- burst_cut  out  1  one-cycle pulse when a grant is released by the MAX_BURST limit rather than by `tlast`.

## Operation
- State machine with two states:
  - IDLE: no grantee.
  - GRANT: forwarding from `grant_id`.
- IDLE → GRANT:
  - Condition: `enable` is high and any `req_tvalid` bit is high.
  - Selected requester: the first one with `tvalid` high, searching from (last+1) mod NUM_REQ upward with wrap-around. `last` is the previous grantee.
  - On entry, the beat counter is cleared.
- In GRANT:
  - `req_tready[grant_id] = !m_axis_tvalid || m_axis_tready`.
  - All other `req_tready` bits are 0.
- Accepted beat (`req_tvalid[g] && req_tready[g]`):
  - Loads the single-entry output register: tdata, `tlast_out = req_tlast[g] || (cnt == MAX_BURST-1)`, and sets `m_axis_tvalid`.
  - Increments `cnt`. `cnt` width is $clog2(MAX_BURST+1).
- Output register:
  - Cleared (tvalid=0) when `m_axis_tready` is high and no new beat is loaded in the same cycle.
  - Simultaneous drain and load in one cycle keeps `m_axis_tvalid` high with the new data.
- GRANT → IDLE:
  - Condition: an accepted beat with `req_tlast` high, or with `cnt == MAX_BURST-1`.
  - `last` is set to the grantee.
  - `burst_cut` pulses in the following cycle, only if `req_tlast` was low on that beat.
  - `grant_valid` drops in the same cycle.
- The output register may still hold the final beat after the return to IDLE; it drains independently of the state.
- A requester that drops `tvalid` mid-packet keeps the grant. The arbiter waits indefinitely; there is no timeout.
- `enable` deasserted in GRANT has no effect until the release.
- MAX_BURST = 1: every beat releases the grant and is forwarded with `m_axis_tlast` = 1.

## Timing
- Reset values:
  - state IDLE, `last` = NUM_REQ-1 (so requester 0 has first priority).
  - `cnt`, `m_axis_tvalid`, `m_axis_tdata`, `m_axis_tlast`, `req_tready`, `grant_valid`, `grant_id`, `burst_cut` all 0.
- Reset asserted mid-packet: the state and output register are cleared immediately. The beat held in the output register is lost, and the requester must resend.
- Arbitration latency:
  - `tvalid` high in IDLE at cycle 0 → `grant_valid`/`req_tready` high in cycle 1.
  - First beat accepted in cycle 1 → `m_axis_tvalid` high in cycle 2.
- Throughput: one beat per cycle within a grant when `m_axis_tready` is held high.
- Inter-grant gap: exactly one IDLE cycle.
- `req_tready` is combinational from `m_axis_tready` and registered state. There is no combinational path from `req_tvalid` to `req_tready`.

## Test plan
- Single packet: requester 2 sends 0x41, 0x42, 0x43 (tlast on 0x43) with `m_axis_tready`=1 → `m_axis_tdata` shows 0x41, 0x42, 0x43 on cycles 2–4; `m_axis_tlast` only on 0x43; `grant_id`=2; `grant_valid` low from cycle 4.
- Round-robin fairness: all four requesters continuously send 1-beat packets → grant order is 0, 1, 2, 3, 0, …, with one idle cycle between grants.
- No interleave: requester 0 sends 5 beats and requester 1 raises `tvalid` during beat 2 → requester 1 is granted only after requester 0's tlast beat; the output stream is 5×r0 then r1.
- Burst cut: MAX_BURST=4, requester 1 sends 6 beats without tlast → after 4 beats the grant is released, beat 4 carries `m_axis_tlast`=1, `burst_cut` pulses once, and requester 1 is re-granted for the remaining 2 beats when it is the only requester.
- Back-pressure: `m_axis_tready` low for 10 cycles mid-packet → `req_tready` is low during the stall, no data is lost or duplicated, and `m_axis_tdata` holds stable while `m_axis_tvalid` is high.
- Enable and reset:
  - `enable`=0 with requests pending → no grant.
  - `enable` dropped mid-packet → the packet completes, then no new grant.
  - `rst_n` pulsed mid-packet → all outputs are 0 in the same cycle, and after reset requester 0 wins first.
